// File: rtl/instr_fetch.sv
// Instruction fetch front end: drives instr_mem, buffers words in a prefetch FIFO, handles redirect/halt.
// Optional fetched-word counter enabled by defining FETCH_PERF_EN.
module instr_fetch #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    DEPTH       = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [DATA_WIDTH-1:0] HALT_OPCODE = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    output logic [ADDR_WIDTH-1:0] imem_pc,
    input  logic [DATA_WIDTH-1:0] imem_instr,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  halted,
    output logic [31:0]           fetch_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [DATA_WIDTH-1:0] buf_instr [DEPTH];
    logic [ADDR_WIDTH-1:0] buf_pc    [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W:0]        count;
    logic                  push;
    logic                  pop;

    // Handshake: a word transfers on any edge where out_valid and out_ready are both high;
    // out_* stay stable while out_valid is high and out_ready is low.
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign push      = (state == FETCH) & fetch_en & ~redirect_valid
                     & ((count < FULL_COUNT) | pop);

    assign imem_pc   = fetch_pc;
    assign out_instr = out_valid ? buf_instr[rd_ptr] : '0;
    assign out_pc    = out_valid ? buf_pc[rd_ptr]    : '0;
    assign halted    = (state == HALT) & (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            // Redirect flushes everything, ignores any pop and leaves HALT.
            state    <= FETCH;
            fetch_pc <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                fetch_pc <= fetch_pc + 1'b1;
                if (imem_instr == HALT_OPCODE) begin
                    state <= HALT;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage needs no reset: contents are only visible through a non-zero count.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= imem_instr;
            buf_pc[wr_ptr]    <= fetch_pc;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (push && (fetch_count != 32'hFFFF_FFFF)) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`else
    assign fetch_count = '0;
`endif

endmodule
